west_feeder: RTL
================

WEST_FEEDER -- requirements
Module: west_feeder

Interface
REQ-001 Parameter row, default 8: number of array rows driven.
REQ-002 Parameter col, default 8: number of tile columns loaded per kernel.
REQ-003 Parameter bw, default 4: activation/weight width per row.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high clear of all state.
REQ-007 start  input  1  one-cycle request to begin a load+execute job; honoured only in IDLE.
REQ-008 separateweights  input  1  1: two weight vectors per column (16x8 mode); 0: one (8x8 mode); sampled on accepted start.
REQ-009 n_act  input  8  activation vectors to stream in EXEC; sampled on accepted start.
REQ-010 in_data  input  row*bw  weight or activation vector from the input buffer.
REQ-011 in_valid  input  1  in_data valid.
REQ-012 in_ready  output  1  feeder accepts in_data this cycle.
REQ-013 out_w  output  row*bw  per-row west data into the array (row r at bits [r*bw +: bw]).
REQ-014 inst_w  output  2*row  per-row instruction (row r at bits [2r +: 2]); bit1 execute, bit0 kernel load.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on DRAIN exit.

Function
REQ-017 States: IDLE, LOAD, GAP, EXEC, DRAIN; state, counters and configuration are registered.
REQ-018 IDLE -> LOAD on start; start in any other state is ignored.
REQ-019 Transfer occurs when in_valid and in_ready are both high; in_ready is high only in LOAD and EXEC.
REQ-020 LOAD accepts exactly col transfers (2*col if sampled separateweights=1), then -> GAP.
REQ-021 GAP lasts exactly one cycle with no transfer, then -> EXEC, or -> DRAIN if n_act=0.
REQ-022 EXEC accepts exactly n_act transfers, then -> DRAIN.
REQ-023 DRAIN lasts exactly col+row cycles, then -> IDLE with done=1 in the IDLE-entry cycle.
REQ-024 Row-0 stage: one cycle after a LOAD transfer, out_w row 0 = in_data row 0 slice and inst = 2'b01; after an EXEC transfer, inst = 2'b10.
REQ-025 Cycles without a transfer (bubble, GAP, DRAIN, IDLE) produce inst 2'b00 and hold out_w at its last value; transfer counts do not advance.
REQ-026 Row r stage equals row 0 stage delayed r cycles (diagonal skew) when FEEDER_SKEW_EN is defined.
REQ-027 Transfer counters are 9 bits; no wrap within one job (max 255 EXEC or 2*col LOAD).

Reset
REQ-028 On reset: state IDLE, all counters 0, in_ready=0, busy=0, done=0, out_w=0, inst_w=0, all skew registers 0.
REQ-029 Reset mid-job aborts immediately; no done pulse; next start begins a fresh job.

Configuration
REQ-030 Macro FEEDER_SKEW_EN defined: per-row skew registers of depth r for row r (REQ-026).
REQ-031 Macro FEEDER_SKEW_EN undefined: all rows use the row-0 stage in the same cycle (skew done externally); DRAIN still lasts col+row cycles.

Verification (row=8, col=8, bw=4)
REQ-032 Assert reset during activity -> next edge: out_w=0, inst_w=0, busy=0, in_ready=0, done=0.
REQ-033 start, separateweights=0, n_act=4, in_valid held 1 -> 8 load transfers, row-0 inst 01 x8, 00 x1 (GAP), 10 x4; done exactly 16 DRAIN cycles after the last EXEC transfer.
REQ-034 separateweights=1, n_act=2 -> exactly 16 load transfers before GAP; row-0 inst 01 x16.
REQ-035 in_valid pattern 1,0,1,0 in LOAD -> row-0 inst 01,00,01,00; load count still ends at 8.
REQ-036 FEEDER_SKEW_EN defined: row-7 inst/out_w sequence equals row-0 sequence shifted by 7 cycles; undefined: identical in the same cycle.
REQ-037 n_act=0 -> GAP then DRAIN with no inst 10 on any row; done after 16 DRAIN cycles; start during busy has no effect.

Source files
------------

// File: rtl/west_feeder_if.sv
// west_feeder_if: input-buffer handshake into the west feeder.
// The master drives one row*bw vector plus valid; the slave (feeder) returns ready.
interface west_feeder_if #(
  parameter int row = 8,
  parameter int bw  = 4
);
  logic [row*bw-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/west_feeder.sv
// west_feeder: loads col (or 2*col) weight vectors, idles one GAP cycle,
// streams n_act activation vectors, then drains col+row cycles before done.
// Each accepted vector is registered into a stage that drives the array's
// west edge together with a 2-bit instruction (bit1 execute, bit0 load).
// Build option FEEDER_SKEW_EN: row r sees the stage delayed r cycles
// (diagonal skew); without it every row uses the stage in the same cycle.
module west_feeder #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int bw  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                separateweights,
  input  logic [7:0]          n_act,
  west_feeder_if.slave        in_if,
  output logic [row*bw-1:0]   out_w,
  output logic [2*row-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_DRAIN
  } state_t;

  localparam logic [8:0] LOAD_ONE  = 9'(col);
  localparam logic [8:0] LOAD_TWO  = 9'(2 * col);
  localparam logic [8:0] DRAIN_LEN = 9'(col + row);

  state_t              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                sep_q, sep_d;
  logic [7:0]          nact_q, nact_d;
  logic [row*bw-1:0]   w_q, w_d;
  logic [1:0]          inst0_q, inst0_d;
  logic                done_q, done_d;
  logic                xfer;
  logic [8:0]          load_tgt;

  // Next-state, transfer counting and row-0 stage update
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sep_d          = sep_q;
    nact_d         = nact_q;
    w_d            = w_q;
    inst0_d        = 2'b00;
    done_d         = 1'b0;
    in_if.in_ready = (state_q == S_LOAD) || (state_q == S_EXEC);
    xfer           = in_if.in_valid && in_if.in_ready;
    load_tgt       = sep_q ? LOAD_TWO : LOAD_ONE;

    if (xfer) begin
      w_d     = in_if.in_data;
      inst0_d = (state_q == S_LOAD) ? 2'b01 : 2'b10;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          sep_d   = separateweights;
          nact_d  = n_act;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (cnt_q + 9'd1 == load_tgt) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      S_GAP: begin
        state_d = (nact_q == 8'd0) ? S_DRAIN : S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC: begin
        if (xfer) begin
          if (cnt_q + 9'd1 == {1'b0, nact_q}) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LEN - 9'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, configuration and stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sep_q   <= 1'b0;
      nact_q  <= '0;
      w_q     <= '0;
      inst0_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sep_q   <= sep_d;
      nact_q  <= nact_d;
      w_q     <= w_d;
      inst0_q <= inst0_d;
      done_q  <= done_d;
    end
  end

  // Status outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
  end

`ifdef FEEDER_SKEW_EN
  assign out_w[bw-1:0] = w_q[bw-1:0];
  assign inst_w[1:0]   = inst0_q;

  for (genvar r = 1; r < row; r++) begin : g_skew
    localparam int SW = bw + 2;
    logic [SW-1:0]   stage;
    logic [r*SW-1:0] dly_q;

    assign stage = {inst0_q, w_q[r*bw +: bw]};

    if (r == 1) begin : g_d1
      // Single-cycle delay for row 1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) dly_q <= '0;
        else       dly_q <= stage;
      end
    end else begin : g_dn
      // Shift row r's stage through r registers; oldest entry at the top
      always_ff @(posedge clk or posedge reset) begin
        if (reset) dly_q <= '0;
        else       dly_q <= {dly_q[(r-1)*SW-1:0], stage};
      end
    end

    assign out_w[r*bw +: bw] = dly_q[r*SW-1 -: SW][bw-1:0];
    assign inst_w[2*r +: 2]  = dly_q[r*SW-1 -: SW][SW-1 -: 2];
  end
`else
  // Every row takes the row-0 stage in the same cycle
  always_comb begin
    out_w = w_q;
    for (int unsigned r = 0; r < row; r++) begin
      inst_w[2*r +: 2] = inst0_q;
    end
  end
`endif

endmodule
